pll_acq_sequencer: RTL and testbench

//  Acquisition/gain-scheduling controller for the PLL loop filter. Watches the phase-detector
//  up/dn pulses, drives the loop filter's reset and step size, and sequences the loop through

---
 rtl/pll_ctrl_pkg.sv | 29 ++
 rtl/pll_activity_window.sv | 57 +++++
 rtl/pll_acq_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_pll_acq_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
//   Constants shared by the PLL acquisition sequencer, the loop filter and the bench:
//   the 2-bit controller state encoding and the {up, dn} phase-detector pulse-pair decode.
//   No ports (package). Configuration macro used by the sequencer: PLL_ACQ_TIMEOUT_EN.
package pll_ctrl_pkg;

  // Controller state, visible on state_out.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COARSE = 2'd1,
    ST_FINE   = 2'd2,
    ST_LOCKED = 2'd3
  } pll_state_e;

  // Phase-detector pulse pair, packed as {up, dn}.
  localparam logic [1:0] PD_NONE = 2'b00;
  localparam logic [1:0] PD_DN   = 2'b01;
  localparam logic [1:0] PD_UP   = 2'b10;
  localparam logic [1:0] PD_BOTH = 2'b11;

  localparam logic [7:0] RETRY_MAX = 8'd255;

  // A cycle carries phase error only when exactly one of up/dn is asserted;
  // simultaneous up and dn cancel and count as no error.
  function automatic logic pd_active(input logic [1:0] i_pair);
    return (i_pair == PD_UP) || (i_pair == PD_DN);
  endfunction

endpackage

// File: rtl/pll_activity_window.sv
// pll_activity_window
//   Fixed-length observation window over the phase-detector activity flag.
//   Ports:
//     i_clk       system clock (rising edge)
//     i_rst       synchronous active-high reset
//     i_run       1 = window counting enabled (controller not idle)
//     i_clr       restart the window (asserted on every controller state change)
//     i_active    this cycle carries phase error
//     o_win_done  last cycle of the current window
//     o_quiet     window total (including this cycle) <= QUIET_THRESH, valid with o_win_done
//     o_noisy     window total (including this cycle) >  LOSS_THRESH, valid with o_win_done
module pll_activity_window
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW       = 256,
  parameter int unsigned QUIET_THRESH = 4,
  parameter int unsigned LOSS_THRESH  = 32
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  input  logic i_active,
  output logic o_win_done,
  output logic o_quiet,
  output logic o_noisy
);

  localparam int unsigned WIN_W = $clog2(WINDOW);
  localparam int unsigned ACT_W = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] r_win_cnt;
  logic [ACT_W-1:0] r_act_cnt;
  logic [ACT_W-1:0] w_act_total;

  // The evaluation on the last cycle already includes that cycle's activity.
  assign w_act_total = r_act_cnt + ACT_W'(i_active);
  assign o_win_done  = i_run && (r_win_cnt == WIN_LAST);
  assign o_quiet     = (32'(w_act_total) <= QUIET_THRESH);
  assign o_noisy     = (32'(w_act_total) >  LOSS_THRESH);

  // Window position and activity counters; act_cnt is at most WINDOW-1 here so it cannot wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || !i_run) begin
      r_win_cnt <= '0;
      r_act_cnt <= '0;
    end else if (o_win_done) begin
      r_win_cnt <= '0;
      r_act_cnt <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + WIN_W'(1);
      r_act_cnt <= w_act_total;
    end
  end

endmodule

// File: rtl/pll_acq_sequencer.sv
// pll_acq_sequencer
//   Acquisition / gain-scheduling controller for the PLL loop filter. Sequences the loop
//   IDLE -> COARSE -> FINE -> LOCKED from windowed phase-detector activity and drives the
//   loop filter's step size and reset.
//   Optional feature macro: PLL_ACQ_TIMEOUT_EN (FINE-state timeout with retry counter).
//   Ports:
//     i_sys_clk    system clock (rising edge)
//     i_ext_rst    synchronous active-high reset
//     i_enable     1 = run acquisition, 0 = return to IDLE
//     i_up_pulse   phase-detector up
//     i_dn_pulse   phase-detector down
//     o_step_out   loop-filter step size (BIT_COUNT bits)
//     o_lf_rst     loop-filter reset
//     o_locked     1 while LOCKED
//     o_lock_lost  one-cycle pulse on LOCKED -> FINE
//     o_state_out  current state (0 IDLE, 1 COARSE, 2 FINE, 3 LOCKED)
//     o_retry_cnt  saturating timeout retry count (0 without PLL_ACQ_TIMEOUT_EN)
module pll_acq_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned BIT_COUNT       = 24,
  parameter int unsigned COARSE_STEP     = 256,
  parameter int unsigned FINE_STEP       = 1,
  parameter int unsigned WINDOW          = 256,
  parameter int unsigned QUIET_THRESH    = 4,
  parameter int unsigned LOSS_THRESH     = 32,
  parameter int unsigned COARSE_WINDOWS  = 2,
`ifdef PLL_ACQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_WINDOWS = 64,
`endif
  parameter int unsigned LOCK_WINDOWS    = 4
)(
  input  logic                 i_sys_clk,
  input  logic                 i_ext_rst,
  input  logic                 i_enable,
  input  logic                 i_up_pulse,
  input  logic                 i_dn_pulse,
  output logic [BIT_COUNT-1:0] o_step_out,
  output logic                 o_lf_rst,
  output logic                 o_locked,
  output logic                 o_lock_lost,
  output logic [1:0]           o_state_out,
  output logic [7:0]           o_retry_cnt
);

  localparam int unsigned QR_MAX = (COARSE_WINDOWS > LOCK_WINDOWS) ? COARSE_WINDOWS : LOCK_WINDOWS;
  localparam int unsigned QR_W   = $clog2(QR_MAX + 1);
  localparam logic [BIT_COUNT-1:0] STEP_COARSE = BIT_COUNT'(COARSE_STEP);
  localparam logic [BIT_COUNT-1:0] STEP_FINE   = BIT_COUNT'(FINE_STEP);

  pll_state_e           r_state;
  pll_state_e           w_next;
  logic [QR_W-1:0]      r_quiet_run;
  logic [QR_W-1:0]      w_qr_win;
  logic [BIT_COUNT-1:0] r_step;
  logic                 r_lf_rst;
  logic                 r_locked;
  logic                 r_lock_lost;
  logic                 w_active;
  logic                 w_win_done;
  logic                 w_quiet;
  logic                 w_noisy;
  logic                 w_state_chg;
  logic                 w_timeout;
  logic                 w_to_reached;

  assign w_active    = pd_active({i_up_pulse, i_dn_pulse});
  assign w_state_chg = (w_next != r_state);

  pll_activity_window #(
    .WINDOW       (WINDOW),
    .QUIET_THRESH (QUIET_THRESH),
    .LOSS_THRESH  (LOSS_THRESH)
  ) u_window (
    .i_clk      (i_sys_clk),
    .i_rst      (i_ext_rst),
    .i_run      (r_state != ST_IDLE),
    .i_clr      (w_state_chg),
    .i_active   (w_active),
    .o_win_done (w_win_done),
    .o_quiet    (w_quiet),
    .o_noisy    (w_noisy)
  );

  // Quiet-run value that would result from the window ending this cycle (saturating).
  always_comb begin
    w_qr_win = '0;
    if (w_quiet) begin
      if (r_quiet_run == QR_W'(QR_MAX)) begin
        w_qr_win = r_quiet_run;
      end else begin
        w_qr_win = r_quiet_run + QR_W'(1);
      end
    end else begin
      w_qr_win = '0;
    end
  end

  // Next-state logic; a low enable overrides any window evaluation on the same cycle,
  // and lock entry is checked before the FINE timeout.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    if (!i_enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_next = ST_COARSE;
        ST_COARSE: begin
          if (w_win_done && (32'(w_qr_win) >= COARSE_WINDOWS)) begin
            w_next = ST_FINE;
          end else begin
            w_next = ST_COARSE;
          end
        end
        ST_FINE: begin
          if (w_win_done && (32'(w_qr_win) >= LOCK_WINDOWS)) begin
            w_next = ST_LOCKED;
          end else if (w_win_done && w_to_reached) begin
            w_next    = ST_COARSE;
            w_timeout = 1'b1;
          end else begin
            w_next = ST_FINE;
          end
        end
        ST_LOCKED: begin
          if (w_win_done && w_noisy) begin
            w_next = ST_FINE;
          end else begin
            w_next = ST_LOCKED;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State, quiet-run and registered outputs; outputs follow the next state so they change
  // on the same edge as the state.
  always_ff @(posedge i_sys_clk) begin
    if (i_ext_rst) begin
      r_state     <= ST_IDLE;
      r_quiet_run <= '0;
      r_step      <= STEP_COARSE;
      r_lf_rst    <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_step      <= ((w_next == ST_FINE) || (w_next == ST_LOCKED)) ? STEP_FINE : STEP_COARSE;
      r_lf_rst    <= (w_next == ST_IDLE) || w_timeout;
      r_locked    <= (w_next == ST_LOCKED);
      r_lock_lost <= (r_state == ST_LOCKED) && (w_next == ST_FINE);
      if (w_state_chg) begin
        r_quiet_run <= '0;
      end else if (w_win_done) begin
        r_quiet_run <= w_qr_win;
      end else begin
        r_quiet_run <= r_quiet_run;
      end
    end
  end

`ifdef PLL_ACQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_WINDOWS + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_retry_cnt;

  assign w_to_reached = ((32'(r_to_cnt) + 32'd1) >= TIMEOUT_WINDOWS);
  assign o_retry_cnt  = r_retry_cnt;

  // Completed FINE windows since FINE entry, and the saturating retry count.
  always_ff @(posedge i_sys_clk) begin
    if (i_ext_rst) begin
      r_to_cnt    <= '0;
      r_retry_cnt <= 8'd0;
    end else begin
      if (w_state_chg) begin
        r_to_cnt <= '0;
      end else if (w_win_done && (r_state == ST_FINE)) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= r_to_cnt;
      end
      if (w_timeout && (r_retry_cnt != RETRY_MAX)) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end else begin
        r_retry_cnt <= r_retry_cnt;
      end
    end
  end
`else
  assign w_to_reached = 1'b0;
  assign o_retry_cnt  = 8'd0;
`endif

  assign o_state_out = r_state;
  assign o_step_out  = r_step;
  assign o_lf_rst    = r_lf_rst;
  assign o_locked    = r_locked;
  assign o_lock_lost = r_lock_lost;

endmodule

// File: tb/tb_pll_acq_sequencer.sv
// tb_pll_acq_sequencer
//   Directed plus randomized bench for pll_acq_sequencer with a cycle-level behavioural
//   reference model of the acquisition rules. Honours PLL_ACQ_TIMEOUT_EN.
module tb_pll_acq_sequencer;

  localparam int W  = 16;
  localparam int QT = 2;
  localparam int LT = 8;
  localparam int CW = 2;
  localparam int LW = 3;
  localparam int CS = 256;
  localparam int FS = 1;
`ifdef PLL_ACQ_TIMEOUT_EN
  localparam int TW = 4;
`endif

  logic        clk = 1'b0;
  logic        ext_rst = 1'b1;
  logic        enable = 1'b0;
  logic        up = 1'b0;
  logic        dn = 1'b0;
  logic [23:0] step_out;
  logic        lf_rst;
  logic        locked;
  logic        lock_lost;
  logic [1:0]  state_out;
  logic [7:0]  retry_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_state = 0;
  int m_pos = 0;
  int m_acts = 0;
  int m_qrun = 0;
  int m_to = 0;
  int m_retry = 0;
  int m_step = CS;
  int m_lf = 1;
  int m_lk = 0;
  int m_ll = 0;

  always #5 clk = ~clk;

  pll_acq_sequencer #(
    .BIT_COUNT       (24),
    .COARSE_STEP     (CS),
    .FINE_STEP       (FS),
    .WINDOW          (W),
    .QUIET_THRESH    (QT),
    .LOSS_THRESH     (LT),
    .COARSE_WINDOWS  (CW),
`ifdef PLL_ACQ_TIMEOUT_EN
    .TIMEOUT_WINDOWS (TW),
`endif
    .LOCK_WINDOWS    (LW)
  ) dut (
    .i_sys_clk   (clk),
    .i_ext_rst   (ext_rst),
    .i_enable    (enable),
    .i_up_pulse  (up),
    .i_dn_pulse  (dn),
    .o_step_out  (step_out),
    .o_lf_rst    (lf_rst),
    .o_locked    (locked),
    .o_lock_lost (lock_lost),
    .o_state_out (state_out),
    .o_retry_cnt (retry_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge of the acquisition rules applied to the sampled inputs.
  task automatic model_edge(input bit rst, input bit en, input bit u, input bit d);
    int nxt;
    int total;
    int qr;
    bit tpulse;
    bit done;
    if (rst) begin
      m_state = 0; m_pos = 0; m_acts = 0; m_qrun = 0; m_to = 0; m_retry = 0;
      m_step = CS; m_lf = 1; m_lk = 0; m_ll = 0;
      return;
    end
    nxt    = m_state;
    tpulse = 1'b0;
    done   = (m_state != 0) && (m_pos == W - 1);
    total  = m_acts + int'(u ^ d);
    qr     = (total <= QT) ? m_qrun + 1 : 0;
    if (!en) nxt = 0;
    else if (m_state == 0) nxt = 1;
    else if (done) begin
      if (m_state == 1 && qr >= CW) nxt = 2;
      else if (m_state == 2 && qr >= LW) nxt = 3;
      else if (m_state == 3 && total > LT) nxt = 2;
`ifdef PLL_ACQ_TIMEOUT_EN
      else if (m_state == 2 && m_to + 1 >= TW) begin
        nxt = 1;
        tpulse = 1'b1;
        if (m_retry < 255) m_retry++;
      end
`endif
    end
    m_ll = (m_state == 3 && nxt == 2) ? 1 : 0;
    if (nxt != m_state) begin
      m_pos = 0; m_acts = 0; m_qrun = 0; m_to = 0;
    end else if (done) begin
      m_pos = 0; m_acts = 0; m_qrun = qr;
      if (m_state == 2) m_to++;
    end else if (m_state != 0) begin
      m_pos++;
      m_acts += int'(u ^ d);
    end
    m_state = nxt;
    m_lf    = (nxt == 0 || tpulse) ? 1 : 0;
    m_step  = (nxt >= 2) ? FS : CS;
    m_lk    = (nxt == 3) ? 1 : 0;
  endtask

  // Drive one cycle, advance the model on the edge, compare all outputs 1 time unit later.
  task automatic cyc(input bit rst, input bit en, input bit u, input bit d);
    ext_rst = rst; enable = en; up = u; dn = d;
    @(posedge clk);
    model_edge(rst, en, u, d);
    #1;
    check("state", 32'(state_out), 32'(m_state));
    check("step", 32'(step_out), 32'(m_step));
    check("lf_rst", 32'(lf_rst), 32'(m_lf));
    check("locked", 32'(locked), 32'(m_lk));
    check("lock_lost", 32'(lock_lost), 32'(m_ll));
    check("retry", 32'(retry_cnt), 32'(m_retry));
  endtask

  initial begin
    int pct;
    bit en_r;
    bit rst_r;

    // 1: reset, then idle with enable low
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("idle_state", 32'(state_out), 32'd0);
    check("idle_lf_rst", 32'(lf_rst), 32'd1);
    check("idle_step", 32'(step_out), 32'd256);

    // 2: clean acquisition
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("coarse_entry", 32'(state_out), 32'd1);
    check("coarse_lf_rst", 32'(lf_rst), 32'd0);
    repeat (31) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("coarse_hold", 32'(state_out), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("fine_entry", 32'(state_out), 32'd2);
    check("fine_step", 32'(step_out), 32'd1);
    repeat (47) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("fine_hold", 32'(state_out), 32'd2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("lock_entry", 32'(state_out), 32'd3);
    check("lock_flag", 32'(locked), 32'd1);

    // 3: noisy window in LOCKED (9 active cycles)
    repeat (9) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("loss_state", 32'(state_out), 32'd2);
    check("loss_pulse", 32'(lock_lost), 32'd1);
    check("loss_locked", 32'(locked), 32'd0);

    // 4: in FINE, a non-quiet second window restarts the quiet run; up=dn=1 counts as quiet
    repeat (16) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("pulse_one_cycle", 32'(lock_lost), 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (13) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (32) cyc(1'b0, 1'b1, 1'b1, 1'b1);
`ifndef PLL_ACQ_TIMEOUT_EN
    check("qrun_cleared", 32'(state_out), 32'd2);
`endif
    repeat (16) cyc(1'b0, 1'b1, 1'b1, 1'b1);
`ifndef PLL_ACQ_TIMEOUT_EN
    check("relock", 32'(state_out), 32'd3);
`endif

    // 3b: 5 active cycles in a window stay between thresholds
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (11) cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // 5: enable low mid-window, and on a noisy win_done cycle
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("dis_state", 32'(state_out), 32'd0);
    check("dis_lf_rst", 32'(lf_rst), 32'd1);
    check("dis_no_pulse", 32'(lock_lost), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (80) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("lock_again", 32'(state_out), 32'd3);
    repeat (14) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("dis_wd_state", 32'(state_out), 32'd0);
    check("dis_wd_no_pulse", 32'(lock_lost), 32'd0);

`ifdef PLL_ACQ_TIMEOUT_EN
    // 6: FINE timeout with toggling up pulses, then reset mid-FINE
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (32) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("to_fine", 32'(state_out), 32'd2);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'(i % 2), 1'b0);
    check("to_state", 32'(state_out), 32'd1);
    check("to_retry", 32'(retry_cnt), 32'd1);
    check("to_lf_pulse", 32'(lf_rst), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("to_lf_end", 32'(lf_rst), 32'd0);
    repeat (31) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_step", 32'(step_out), 32'd256);
`endif

    // randomized windows of varying activity density
    for (int w = 0; w < 80; w++) begin
      case ($urandom_range(0, 3))
        0: pct = 0;
        1: pct = 8;
        2: pct = 30;
        default: pct = 70;
      endcase
      for (int c = 0; c < W; c++) begin
        en_r  = ($urandom_range(0, 299) != 0);
        rst_r = ($urandom_range(0, 999) == 0);
        cyc(rst_r, en_r, ($urandom_range(0, 99) < pct), ($urandom_range(0, 99) < pct));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
